// File: rtl/sum_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// sum_acc_pkg: shared state encoding and default widths for sum_accumulator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sum_acc_pkg;

  localparam int SUM_W_DEFAULT = 6;
  localparam int ACC_W_DEFAULT = 12;
  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sum_accumulator_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add: W-bit adder with carry out; clamps to all-ones on carry when
// SUM_ACCUMULATOR_SATURATE_EN is defined, otherwise wraps.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  // Once clamped, any further non-zero operand carries again and re-clamps.
  assign sum = carry ? {W{1'b1}} : full[W-1:0];
`else
  assign sum = full[W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator: sums a programmed number of 7-bit adder results into a
// wide total with sticky overflow. Option macro: SUM_ACCUMULATOR_SATURATE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int PAD_W = ACC_W - SUM_W - 1;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign operand = {{PAD_W{1'b0}}, in_cout, in_sum};

  sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a     (acc_q),
    .b     (operand),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = num_ops;
          acc_d       = '0;
          ovf_d       = 1'b0;
          state_d     = (num_ops == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d       = add_sum;
          ovf_d       = ovf_q | add_carry;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      remaining_q <= remaining_d;
    end
  end

  // Handshake outputs decode only from registered state.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == ACC) || (state_q == HOLD);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator: table-driven scoreboard bench for sum_accumulator,
// checking a 12-bit and an 8-bit instance driven in lock-step.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_ops = '0;
  logic       in_valid = 1'b0;
  logic [5:0] in_sum = '0;
  logic       in_cout = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [11:0] out_acc_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [7:0]  out_acc_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.SUM_W(6), .ACC_W(12), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
    .out_ovf(out_ovf_a), .busy(busy_a)
  );

  sum_accumulator #(.SUM_W(6), .ACC_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
    .out_ovf(out_ovf_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [3:0]       num;
    logic [14:0][6:0] ops;
    logic [3:0]       gap;
    logic [3:0]       hold;
    logic             start_pulse;
    logic [11:0]      acc12;
    logic             ovf12;
    logic [7:0]       acc8;
    logic             ovf8;
  } vec_t;

  typedef struct packed {
    logic [11:0] acc12;
    logic        ovf12;
    logic [7:0]  acc8;
    logic        ovf8;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    start   = 1'b1;
    num_ops = v.num;
    tick();
    start   = 1'b0;
    check("busy_after_start_a", int'(busy_a), 1);
    check("busy_after_start_b", int'(busy_b), 1);
    sb.push_back('{acc12: v.acc12, ovf12: v.ovf12, acc8: v.acc8, ovf8: v.ovf8});
    if (v.num == 4'd0) check("in_ready_zero_ops", int'(in_ready_a), 0);
    for (int i = 0; i < int'(v.num); i++) begin
      if (i > 0) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          in_valid = 1'b0;
          if (v.start_pulse && g == 0) begin
            start   = 1'b1;
            num_ops = 4'd0;
          end
          tick();
          start = 1'b0;
        end
      end
      in_valid = 1'b1;
      {in_cout, in_sum} = v.ops[i];
      check("in_ready_acc", int'(in_ready_a), 1);
      tick();
    end
    in_valid = 1'b0;
    check("out_valid_next_cycle_a", int'(out_valid_a), 1);
    check("out_valid_next_cycle_b", int'(out_valid_b), 1);
    check("in_ready_hold", int'(in_ready_a), 0);
    for (int h = 0; h < int'(v.hold); h++) begin
      check("acc_stable_hold", int'(out_acc_a), int'(sb[0].acc12));
      check("out_valid_hold", int'(out_valid_a), 1);
      check("in_ready_hold_bp", int'(in_ready_a), 0);
      tick();
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    check("out_acc_a", int'(out_acc_a), int'(e.acc12));
    check("out_ovf_a", int'(out_ovf_a), int'(e.ovf12));
    check("out_acc_b", int'(out_acc_b), int'(e.acc8));
    check("out_ovf_b", int'(out_ovf_b), int'(e.ovf8));
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", int'(out_valid_a), 0);
    check("busy_drop", int'(busy_a), 0);
    check("acc_kept_after_hs", int'(out_acc_a), int'(e.acc12));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t r;
    for (int k = 0; k < 5; k++) vecs[k] = '0;
    // Basic: (0,33),(1,0),(0,63) = 33+64+63
    vecs[0].num = 4'd3;
    vecs[0].ops[0] = 7'd33; vecs[0].ops[1] = 7'd64; vecs[0].ops[2] = 7'd63;
    vecs[0].acc12 = 12'd160; vecs[0].acc8 = 8'd160;
    // Backpressure with an ignored start while busy
    vecs[1] = vecs[0];
    vecs[1].gap = 4'd2; vecs[1].hold = 4'd5; vecs[1].start_pulse = 1'b1;
    // Zero operands
    vecs[2].num = 4'd0;
    // Three x 127: 381 fits 12 bits, overflows 8 bits
    vecs[3].num = 4'd3;
    for (int k = 0; k < 3; k++) vecs[3].ops[k] = 7'd127;
    vecs[3].acc12 = 12'd381; vecs[3].ovf12 = 1'b0; vecs[3].ovf8 = 1'b1;
    // Fifteen x 127 = 1905
    vecs[4].num = 4'd15;
    for (int k = 0; k < 15; k++) vecs[4].ops[k] = 7'd127;
    vecs[4].acc12 = 12'd1905; vecs[4].ovf12 = 1'b0; vecs[4].ovf8 = 1'b1;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    vecs[3].acc8 = 8'd255;
    vecs[4].acc8 = 8'd255;
`else
    vecs[3].acc8 = 8'd125;
    vecs[4].acc8 = 8'd113;
`endif

    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready_a), 0);
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_out_acc", int'(out_acc_a), 0);
    check("rst_out_ovf", int'(out_ovf_a), 0);
    check("rst_busy", int'(busy_a), 0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      run_vec(vecs[k]);
      tick();
    end

    // Reset in the middle of a four-operand run
    start = 1'b1; num_ops = 4'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; {in_cout, in_sum} = 7'd100;
      tick();
    end
    check("mid_acc_before_rst", int'(out_acc_a), 200);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_acc", int'(out_acc_a), 0);
    check("mid_rst_ovf_b", int'(out_ovf_b), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_in_ready", int'(in_ready_a), 0);
    check("mid_rst_out_valid", int'(out_valid_a), 0);
    rst_n = 1'b1;
    tick();
    r = '0;
    r.num = 4'd1; r.ops[0] = 7'd5; r.acc12 = 12'd5; r.acc8 = 8'd5;
    run_vec(r);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sum_accumulator.md
# sum_accumulator

- Multi-operand accumulator that sits directly downstream of the 6-bit adders (CLA and serial).
- Consumes a programmed number of adder results, each the 7-bit value {Cout, S}, and sums them into a wide running total.
- Presents the total and a sticky overflow flag through a valid/ready output handshake.
- Lets the adder stage chain into multi-operand sums without host-side bookkeeping.

## Interface
Parameters:
- SUM_W, 6, width of the adder sum field S
- ACC_W, 12, accumulator width
- CNT_W, 4, operand-count width (max 2^CNT_W−1 operands)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a new accumulation; sampled only in IDLE
- num_ops  in  CNT_W  number of adder results to accumulate; sampled with start
- in_valid  in  1  adder result available
- in_ready  out  1  accumulator accepts a result
- in_sum  in  SUM_W  adder S
- in_cout  in  1  adder Cout
- out_valid  out  1  total available
- out_ready  in  1  consumer takes the total
- out_acc  out  ACC_W  accumulated total
- out_ovf  out  1  sticky overflow for the current accumulation
- busy  out  1  high in ACC and HOLD

## Operation
- Operand value: zero-extend {in_cout, in_sum} (range 0..127 at default widths) to ACC_W.
- FSM states: IDLE, ACC, HOLD.
- IDLE:
  - On start, load remaining=num_ops and clear acc and ovf.
  - If num_ops==0, go to HOLD with acc=0; otherwise go to ACC.
  - start is ignored in ACC and HOLD.
- ACC:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready: acc ← acc + operand and remaining ← remaining−1.
  - If the accepted beat had remaining==1, go to HOLD.
  - Cycles with in_valid=0 change nothing.
- HOLD:
  - out_valid=1 and in_ready=0.
  - On out_ready, go to IDLE.
- Carry out of the ACC_W add sets ovf. ovf stays set until the next start or reset.
- Without SATURATE_EN, acc wraps modulo 2^ACC_W.
- After handshake completion, out_acc and out_ovf keep their last values until the next start.
- Reset (any state, including mid-accumulation): next edge gives state=IDLE, acc=0, ovf=0, remaining=0. In-flight operands are discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
- in_ready, out_valid and busy decode from the registered state only. There is no combinational path from in_valid or out_ready.
- start in IDLE gives busy=1 and in_ready=1 (or out_valid=1 when num_ops==0) from the next cycle.
- Each accepted beat updates acc on the same edge. Throughput is one operand per cycle.
- The edge that accepts the final beat registers out_acc and sets out_valid, visible the cycle after the last beat.
- out_acc and out_ovf are stable while out_valid=1 and out_ready=0.
- out_valid deasserts on the edge after out_valid && out_ready. A start sampled in that following IDLE cycle is honoured, so the minimum gap is one cycle.

## Configuration
- Macro: SUM_ACCUMULATOR_SATURATE_EN.
- Defined: on overflow, acc clamps to all-ones (2^ACC_W−1) and stays there for the rest of the accumulation. ovf is set.
- Undefined: acc wraps modulo 2^ACC_W. ovf is set.

## Structure
- Package sum_acc_pkg holds:
  - state typedef enum {IDLE, ACC, HOLD}
  - default constants SUM_W=6, ACC_W=12, CNT_W=4
- One sub-module, sat_add:
  - ACC_W-wide adder with carry out
  - saturation logic compiled under SUM_ACCUMULATOR_SATURATE_EN
- The top module holds the FSM, operand counter and handshake logic.

## Test plan
1. Basic: num_ops=3, results (cout,sum)=(0,33),(1,0),(0,63), back-to-back → out_acc=160, out_ovf=0, out_valid exactly one cycle after the third beat.
2. Backpressure: same stimulus as test 1 with in_valid low for 2 cycles between beats, out_ready low for 5 cycles, and start pulsed while busy:
   - out_acc holds at 160 throughout
   - in_ready=0 in HOLD
   - the start pulse is ignored
3. Zero operands: num_ops=0 → out_valid the cycle after start, out_acc=0, in_ready never asserted.
4. Overflow, ACC_W=8, num_ops=3, each operand (1,63)=127:
   - without the macro: out_acc=125, out_ovf=1
   - with SUM_ACCUMULATOR_SATURATE_EN: out_acc=255, out_ovf=1
5. Reset mid-operation: assert rst_n=0 after 2 of 4 beats → outputs zero and busy=0 after the next edge. A following run with num_ops=1, operand 5 gives out_acc=5, out_ovf=0.
6. Maximum count at defaults: num_ops=15, each operand 127 → out_acc=1905, out_ovf=0.
